seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: match counter width in bits; legal range 1..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 inp  input  1  serial data bit.
REQ-006 in_valid  input  1  inp is sampled only in cycles where in_valid=1.
REQ-007 cfg_load  input  1  one-cycle pulse; loads cfg_pattern and cfg_overlap.
REQ-008 cfg_pattern  input  PAT_W  target pattern; bit PAT_W-1 is the first bit received, bit 0 the last.
REQ-009 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-011 outp  output  1  Mealy match flag, combinational from current state and inputs.
REQ-012 match_cnt  output  CNT_W  saturating count of detected matches.
REQ-013 armed  output  1  1 once a pattern has been loaded (state RUN).
REQ-014 fill  output  clog2(PAT_W)  number of valid history bits held, 0..PAT_W-1.

Function
REQ-015 The block SHALL have two states: IDLE and RUN.
- IDLE -> RUN on cfg_load=1.
- RUN stays in RUN; cfg_load in RUN reloads the configuration.
- Only rst returns the block to IDLE.
REQ-016 In IDLE the block SHALL ignore inp and in_valid, hold outp=0, and hold fill=0.
REQ-017 In RUN the block SHALL keep a history register hist of the last PAT_W-1 accepted bits, newest bit in hist[0].
REQ-018 outp SHALL equal 1 in the same cycle iff all of the following hold: state=RUN, in_valid=1, cfg_load=0, fill=PAT_W-1, and {hist,inp}==pattern register. This is zero-cycle Mealy latency.
REQ-019 On an accepted bit (RUN, in_valid=1, cfg_load=0), hist SHALL shift left with inp entering at bit 0.
REQ-020 On an accepted bit with no match, fill SHALL increment and saturate at PAT_W-1.
REQ-021 On a match with overlap=1, fill SHALL stay at PAT_W-1, so the trailing PAT_W-1 bits can begin the next match.
REQ-022 On a match with overlap=0, fill SHALL clear to 0, so the next match needs PAT_W fresh bits.
REQ-023 Cycles with in_valid=0 SHALL change neither hist nor fill, and SHALL force outp=0.
REQ-024 On cfg_load, the pattern and overlap registers SHALL load from cfg_pattern and cfg_overlap at the next edge.
- hist and fill SHALL clear to 0.
- match_cnt SHALL be kept.
- A concurrent in_valid bit SHALL be discarded and outp SHALL be 0.
REQ-025 match_cnt SHALL increment by 1 on each cycle with outp=1, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-026 cnt_clr SHALL set match_cnt to 0 at the next edge; cnt_clr takes priority over a concurrent match increment.
REQ-027 The pattern register SHALL not be modified by inp traffic; only cfg_load and rst change it.

Reset
REQ-028 With rst=1 at a rising edge, the next state SHALL be:
- state=IDLE, armed=0, fill=0, hist=0, match_cnt=0;
- pattern register=0, overlap register=1.
REQ-029 rst SHALL take priority over cfg_load, cnt_clr and in_valid in the same cycle.
REQ-030 outp SHALL be 0 in every cycle while rst=1 and in the first cycle after reset.
REQ-031 Asserting rst mid-stream SHALL discard any partial match; a bit that would have completed the match after reset SHALL not assert outp.

Verification
REQ-032 Overlap case: PAT_W=4, load pattern 1111 with overlap=1, feed six valid 1s. Required: outp=1 on bits 4, 5 and 6; match_cnt=3.
REQ-033 Non-overlap case: same stimulus with overlap=0. Required: outp=1 on bit 4 only; match_cnt=1; fill=2 after bit 6.
REQ-034 Gaps and count clear: pattern 1011, overlap=1, stream 1,0,1,1,0,1,1 with in_valid=0 gaps between every bit. Required: outp=1 only on the 4th and 7th valid bits, never in gap cycles; match_cnt=2. Then pulse cnt_clr. Required: match_cnt=0 while armed stays 1.
REQ-035 Saturation: CNT_W=2, pattern 1111 with overlap=1, feed eight 1s. Required: match_cnt=3 after the 3rd match (bit 6) and it stays 3 through bit 8.
REQ-036 Reset mid-match and IDLE: feed 1,0,1 of pattern 1011, assert rst for one cycle, then feed 1. Required: outp=0, armed=0, fill=0. Then feed 1011 without any cfg_load. Required: no match while IDLE.
REQ-037 Reload mid-stream: after 1,0,1, pulse cfg_load with pattern 0110 concurrent with in_valid=1, inp=1. Required: outp=0 that cycle and fill=0 next cycle. Then feed 0,1,1,0. Required: outp=1 on the 4th bit.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// Bundles the serial input, configuration and status signals of the sequence detector.
// clk and rst stay outside as plain module ports.
interface seq_detect_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int FILL_W = $clog2(PAT_W);

    logic              inp;
    logic              in_valid;
    logic              cfg_load;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              cfg_overlap;
    logic              cnt_clr;
    logic              outp;
    logic [CNT_W-1:0]  match_cnt;
    logic              armed;
    logic [FILL_W-1:0] fill;

    modport master (
        output inp, in_valid, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
        input  outp, match_cnt, armed, fill
    );

    modport slave (
        input  inp, in_valid, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
        output outp, match_cnt, armed, fill
    );
endinterface

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable pattern, overlap/non-overlap modes,
// zero-latency Mealy match flag and a saturating match counter.
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_param_if.slave  io
);
    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              match;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;

        accept = (state_q == RUN) && io.in_valid && !io.cfg_load;
        // rst gates the flag so a match cannot leak out during the reset cycle
        match  = accept && !rst && (fill_q == FILL_FULL) && ({hist_q, io.inp} == pat_q);

        case (state_q)
            IDLE:    if (io.cfg_load) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (io.cfg_load) begin
            pat_d  = io.cfg_pattern;
            ovl_d  = io.cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = (PAT_W-1)'({hist_q, io.inp});
            if (match)
                fill_d = ovl_q ? FILL_FULL : '0;
            else if (fill_q != FILL_FULL)
                fill_d = fill_q + 1'b1;
        end

        if (io.cnt_clr)
            cnt_d = '0;
        else if (match && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io.outp      = match;
    assign io.match_cnt = cnt_q;
    assign io.armed     = (state_q == RUN);
    assign io.fill      = fill_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed scoreboard bench: stimulus pushes expected outputs, a negedge monitor
// pops and compares them against two detectors (CNT_W=8 and CNT_W=2).
module tb_seq_detect_param;
    logic clk = 1'b1;
    logic rst;
    always #5 clk = ~clk;

    logic       inp, in_valid, cfg_load, cfg_overlap, cnt_clr;
    logic [3:0] cfg_pattern;

    seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if_a ();
    seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) if_b ();

    seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .io(if_a.slave));
    seq_detect_param #(.PAT_W(4), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .io(if_b.slave));

    assign if_a.inp = inp;   assign if_a.in_valid = in_valid; assign if_a.cfg_load = cfg_load;
    assign if_a.cfg_pattern = cfg_pattern; assign if_a.cfg_overlap = cfg_overlap;
    assign if_a.cnt_clr = cnt_clr;
    assign if_b.inp = inp;   assign if_b.in_valid = in_valid; assign if_b.cfg_load = cfg_load;
    assign if_b.cfg_pattern = cfg_pattern; assign if_b.cfg_overlap = cfg_overlap;
    assign if_b.cnt_clr = cnt_clr;

    // -1 in a field means "not checked this cycle"
    typedef struct {
        bit sel_b;
        int o;
        int c;
        int a;
        int f;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    passed = 0;
    int    total  = 0;

    task automatic cmp(input string nm, input string fld, input int act, input int e);
        if (e < 0) return;
        total++;
        if (act == e) passed++;
        else $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, e);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.sel_b) begin
                cmp(nm, "outp",      int'(if_b.outp),      e.o);
                cmp(nm, "match_cnt", int'(if_b.match_cnt), e.c);
                cmp(nm, "armed",     int'(if_b.armed),     e.a);
                cmp(nm, "fill",      int'(if_b.fill),      e.f);
            end else begin
                cmp(nm, "outp",      int'(if_a.outp),      e.o);
                cmp(nm, "match_cnt", int'(if_a.match_cnt), e.c);
                cmp(nm, "armed",     int'(if_a.armed),     e.a);
                cmp(nm, "fill",      int'(if_a.fill),      e.f);
            end
        end
    end

    task automatic drv(input logic v, input logic i, input logic l = 1'b0,
                       input logic [3:0] p = 4'h0, input logic ov = 1'b1,
                       input logic c = 1'b0, input logic r = 1'b0);
        in_valid = v; inp = i; cfg_load = l; cfg_pattern = p;
        cfg_overlap = ov; cnt_clr = c; rst = r;
    endtask

    task automatic ex(input string nm, input bit b, input int o = -1, input int c = -1,
                      input int a = -1, input int f = -1);
        exp_t e;
        e.sel_b = b; e.o = o; e.c = c; e.a = a; e.f = f;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset: outp held low during rst even with valid data present
        drv(1, 1, .r(1)); ex("rst0", 0, 0); nxt();
        drv(1, 1, .r(1)); ex("rst1", 0, 0); nxt();
        drv(1, 1);        ex("post_rst", 0, 0, 0, 0, 0); nxt();

        // overlap, pattern 1111, six ones
        drv(0, 0, 1, 4'b1111, 1); ex("ov_load", 0, 0); nxt();
        drv(1, 1); ex("ov_b1", 0, 0, -1, 1, 0); nxt();
        drv(1, 1); ex("ov_b2", 0, 0, -1, -1, 1); nxt();
        drv(1, 1); ex("ov_b3", 0, 0, -1, -1, 2); nxt();
        drv(1, 1); ex("ov_b4", 0, 1, 0, -1, 3); nxt();
        drv(1, 1); ex("ov_b5", 0, 1, 1, -1, 3); nxt();
        drv(1, 1); ex("ov_b6", 0, 1, 2, -1, 3); nxt();
        drv(0, 1); ex("ov_end", 0, 0, 3, 1, 3); ex("ov_end_b", 1, -1, 3); nxt();

        // non-overlap, same stimulus; counter cleared alongside the load
        drv(0, 0, 1, 4'b1111, 0, 1); ex("no_load", 0, 0, 3, -1, 3); nxt();
        drv(1, 1); ex("no_b1", 0, 0, 0, -1, 0); nxt();
        drv(1, 1); ex("no_b2", 0, 0, -1, -1, 1); nxt();
        drv(1, 1); ex("no_b3", 0, 0, -1, -1, 2); nxt();
        drv(1, 1); ex("no_b4", 0, 1, 0, -1, 3); nxt();
        drv(1, 1); ex("no_b5", 0, 0, 1, -1, 0); nxt();
        drv(1, 1); ex("no_b6", 0, 0, -1, -1, 1); nxt();
        drv(0, 0); ex("no_end", 0, 0, 1, -1, 2); nxt();

        // gaps: pattern 1011, stream 1,0,1,1,0,1,1, gap cycles drive inp=1
        drv(0, 0, 1, 4'b1011, 1, 1); ex("gp_load", 0, 0); nxt();
        drv(1, 1); ex("gp_v1", 0, 0, 0, -1, 0); nxt();
        drv(0, 1); ex("gp_g1", 0, 0); nxt();
        drv(1, 0); ex("gp_v2", 0, 0, -1, -1, 1); nxt();
        drv(0, 1); ex("gp_g2", 0, 0); nxt();
        drv(1, 1); ex("gp_v3", 0, 0, -1, -1, 2); nxt();
        drv(0, 1); ex("gp_g3", 0, 0, -1, -1, 3); nxt();
        drv(1, 1); ex("gp_v4", 0, 1, 0, -1, 3); nxt();
        drv(0, 1); ex("gp_g4", 0, 0, 1); nxt();
        drv(1, 0); ex("gp_v5", 0, 0, 1, -1, 3); nxt();
        drv(0, 1); ex("gp_g5", 0, 0); nxt();
        drv(1, 1); ex("gp_v6", 0, 0); nxt();
        drv(0, 1); ex("gp_g6", 0, 0); nxt();
        drv(1, 1); ex("gp_v7", 0, 1, 1); nxt();
        drv(0, 1); ex("gp_g7", 0, 0, 2, 1); nxt();
        drv(0, 0, .c(1)); ex("gp_clr", 0, 0, 2, 1); nxt();
        drv(0, 0); ex("gp_after_clr", 0, 0, 0, 1); nxt();

        // saturation on the 2-bit counter: eight ones, overlap
        drv(0, 0, 1, 4'b1111, 1, 1); ex("sat_load", 1, 0); nxt();
        drv(1, 1); ex("sat_b1", 1, 0, 0, 1, 0); nxt();
        drv(1, 1); ex("sat_b2", 1, 0, 0); nxt();
        drv(1, 1); ex("sat_b3", 1, 0, 0); nxt();
        drv(1, 1); ex("sat_b4", 1, 1, 0); nxt();
        drv(1, 1); ex("sat_b5", 1, 1, 1); nxt();
        drv(1, 1); ex("sat_b6", 1, 1, 2); nxt();
        drv(1, 1); ex("sat_b7", 1, 1, 3); nxt();
        drv(1, 1); ex("sat_b8", 1, 1, 3); ex("sat_b8_a", 0, -1, 4); nxt();
        drv(0, 0); ex("sat_end", 1, 0, 3, 1, 3); ex("sat_end_a", 0, -1, 5); nxt();

        // reset mid-match: 1,0,1 of 1011, then rst with a completing bit present
        drv(0, 0, 1, 4'b1011, 1); ex("rm_load", 0, 0); nxt();
        drv(1, 1); ex("rm_v1", 0, 0); nxt();
        drv(1, 0); ex("rm_v2", 0, 0); nxt();
        drv(1, 1); ex("rm_v3", 0, 0, -1, 1, 2); nxt();
        drv(1, 1, .r(1)); ex("rm_rst", 0, 0, -1, 1, 3); nxt();
        drv(1, 1); ex("rm_after", 0, 0, 0, 0, 0); nxt();
        drv(1, 1); ex("id_v1", 0, 0, -1, 0, 0); nxt();
        drv(1, 0); ex("id_v2", 0, 0, -1, 0, 0); nxt();
        drv(1, 1); ex("id_v3", 0, 0, -1, 0, 0); nxt();
        drv(1, 1); ex("id_v4", 0, 0, 0, 0, 0); nxt();

        // reload mid-stream: old pattern would complete on the load cycle
        drv(0, 0, 1, 4'b1011, 1); ex("rl_load1", 0, 0, -1, 0); nxt();
        drv(1, 1); ex("rl_v1", 0, 0, -1, 1, 0); nxt();
        drv(1, 0); ex("rl_v2", 0, 0, -1, -1, 1); nxt();
        drv(1, 1); ex("rl_v3", 0, 0, -1, -1, 2); nxt();
        drv(1, 1, 1, 4'b0110, 1); ex("rl_load2", 0, 0, 0, 1, 3); nxt();
        drv(1, 0); ex("rl_n1", 0, 0, -1, 1, 0); nxt();
        drv(1, 1); ex("rl_n2", 0, 0, -1, -1, 1); nxt();
        drv(1, 1); ex("rl_n3", 0, 0, -1, -1, 2); nxt();
        drv(1, 0); ex("rl_n4", 0, 1, 0, -1, 3); nxt();
        drv(0, 0); ex("rl_end", 0, 0, 1, 1, 3); nxt();

        nxt();
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
